// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the output pulse stretcher and the event counters
// that feed it.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  localparam int TICK_W = 8;

  // Default high/guard lengths used by the LED and relay instances.
  localparam int DEF_ON_TICKS  = 5;
  localparam int DEF_OFF_TICKS = 5;

endpackage

// File: rtl/event_counter.sv
// Saturating up/down event counter; reports a dropped increment on ovf_set.
module event_counter #(
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             ovf_set
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Simultaneous inc and dec cancel, so a full counter can still accept one.
  assign ovf_set = inc && !dec && (count == CNT_MAX);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (inc && !dec && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pulse_stretcher.sv
// Turns one-cycle events into clean high/low pulses timed in PULSE_5MS ticks;
// events arriving while busy are queued in a saturating counter.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int ON_TICKS  = DEF_ON_TICKS,
  parameter int OFF_TICKS = DEF_OFF_TICKS,
  parameter int CNT_W     = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              PULSE_5MS,
  input  logic              EVENT,
  input  logic              CLEAR_OVF,
  output logic              OUT_LEVEL,
  output logic              BUSY,
  output logic [CNT_W-1:0]  PENDING,
  output logic              OVERFLOW,
  output state_t            STATE_DBG,
  output logic [TICK_W-1:0] TICK_DBG
);

  // EVENT is a fire-and-forget strobe: every high cycle is one request, there
  // is no ready; requests beyond the queue depth are dropped and flagged.
  localparam logic [TICK_W-1:0] ON_LAST  = TICK_W'(ON_TICKS - 1);
  localparam logic [TICK_W-1:0] OFF_LAST = TICK_W'(OFF_TICKS - 1);

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                out_d;
  logic                dec;
  logic                ovf_set;

  assign dec       = (state_q == ST_IDLE) && (PENDING != '0);
  assign BUSY      = (state_q != ST_IDLE);
  assign STATE_DBG = state_q;
  assign TICK_DBG  = tick_q;

  event_counter #(.CNT_W(CNT_W)) u_event_counter (
    .CLK     (CLK),
    .RESET   (RESET),
    .inc     (EVENT),
    .dec     (dec),
    .count   (PENDING),
    .ovf_set (ovf_set)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      OVERFLOW <= 1'b0;
    end else if (ovf_set) begin
      OVERFLOW <= 1'b1;
    end else if (CLEAR_OVF) begin
      OVERFLOW <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      OUT_LEVEL <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      OUT_LEVEL <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    out_d   = OUT_LEVEL;
    case (state_q)
      ST_IDLE: begin
        // Ticks are ignored here so a new pulse always starts at tick 0.
        if (dec) begin
          state_d = ST_ON;
          out_d   = 1'b1;
          tick_d  = '0;
        end
      end
      ST_ON: begin
        if (PULSE_5MS) begin
          if (tick_q == ON_LAST) begin
            state_d = ST_OFF;
            out_d   = 1'b0;
            tick_d  = '0;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      ST_OFF: begin
        out_d = 1'b0;
        if (PULSE_5MS) begin
          if (tick_q == OFF_LAST) begin
            state_d = ST_IDLE;
            tick_d  = '0;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        out_d   = 1'b0;
        tick_d  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher with ON_TICKS=3, OFF_TICKS=2, CNT_W=2 and a
// PULSE_5MS strobe every 10 CLK.
module tb_pulse_stretcher;
  import pulse_stretcher_pkg::*;

  localparam int ON_T  = 3;
  localparam int OFF_T = 2;
  localparam int CW    = 2;
  localparam int W     = 8;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          PULSE_5MS = 1'b0;
  logic          EVENT = 1'b0;
  logic          CLEAR_OVF = 1'b0;
  logic          OUT_LEVEL;
  logic          BUSY;
  logic [CW-1:0] PENDING;
  logic          OVERFLOW;
  state_t        STATE_DBG;
  logic [7:0]    TICK_DBG;

  int checks = 0;
  int failures = 0;
  logic gen_en = 1'b1;
  int div = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_low_q[$];

  int  hi_cnt = 0;
  int  lo_cnt = 0;
  bit  in_high = 0;
  bit  in_low = 0;

  pulse_stretcher #(.ON_TICKS(ON_T), .OFF_TICKS(OFF_T), .CNT_W(CW)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .PULSE_5MS (PULSE_5MS),
    .EVENT     (EVENT),
    .CLEAR_OVF (CLEAR_OVF),
    .OUT_LEVEL (OUT_LEVEL),
    .BUSY      (BUSY),
    .PENDING   (PENDING),
    .OVERFLOW  (OVERFLOW),
    .STATE_DBG (STATE_DBG),
    .TICK_DBG  (TICK_DBG)
  );

  // Clock and tick strobe
  always #5 CLK = ~CLK;

  initial begin
    forever begin
      @(posedge CLK);
      #2;
      PULSE_5MS = gen_en && (div == 9);
      div = (div == 9) ? 0 : div + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  // Driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue_event(input bit accepted);
    EVENT = 1'b1;
    if (accepted) begin
      exp_q.push_back(W'(ON_T));
      exp_low_q.push_back(W'(OFF_T));
    end
    step();
    EVENT = 1'b0;
  endtask

  task automatic wait_out(input logic v);
    int n = 0;
    while (OUT_LEVEL !== v && n < 500) begin
      step();
      n++;
    end
    if (OUT_LEVEL !== v) begin
      checks++;
      failures++;
      $display("FAIL wait_out timeout actual=%0b required=%0b", OUT_LEVEL, v);
    end
  endtask

  task automatic wait_busy(input logic v);
    int n = 0;
    while (BUSY !== v && n < 500) begin
      step();
      n++;
    end
    if (BUSY !== v) begin
      checks++;
      failures++;
      $display("FAIL wait_busy timeout actual=%0b required=%0b", BUSY, v);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (!(BUSY === 1'b0 && PENDING === '0) && n < 1000) begin
      step();
      n++;
    end
    if (!(BUSY === 1'b0 && PENDING === '0)) begin
      checks++;
      failures++;
      $display("FAIL drain timeout busy=%0b pending=%0d required idle/0", BUSY, PENDING);
    end
    repeat (3) step();
  endtask

  // Scoreboard monitor: counts strobes seen in each high and guard phase
  always @(negedge CLK) begin
    if (RESET) begin
      in_high = 0;
      in_low  = 0;
    end else begin
      if (OUT_LEVEL) begin
        if (!in_high) begin
          in_high = 1;
          hi_cnt  = 0;
        end
        if (PULSE_5MS) hi_cnt++;
      end else if (in_high) begin
        in_high = 0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse actual=%0d ticks required=none", hi_cnt);
        end else begin
          check("high_ticks", 32'(hi_cnt), 32'(exp_q.pop_front()));
        end
        in_low = 1;
        lo_cnt = 0;
      end
      if (in_low) begin
        if (!BUSY) begin
          in_low = 0;
          if (exp_low_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_guard actual=%0d ticks required=none", lo_cnt);
          end else begin
            check("low_ticks", 32'(lo_cnt), 32'(exp_low_q.pop_front()));
          end
        end else if (PULSE_5MS) begin
          lo_cnt++;
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) step();
    check("rst_out", 32'(OUT_LEVEL), 0);
    check("rst_pending", 32'(PENDING), 0);
    check("rst_ovf", 32'(OVERFLOW), 0);
    check("rst_busy", 32'(BUSY), 0);
    RESET = 1'b0;
    repeat (2) step();

    // Single event: PENDING=1 after one edge, OUT_LEVEL=1 after two
    issue_event(1);
    check("single_pending_e1", 32'(PENDING), 1);
    check("single_out_e1", 32'(OUT_LEVEL), 0);
    step();
    check("single_out_e2", 32'(OUT_LEVEL), 1);
    check("single_pending_e2", 32'(PENDING), 0);
    check("single_busy_e2", 32'(BUSY), 1);
    drain();
    check("single_ovf", 32'(OVERFLOW), 0);

    // Queueing: three events during the first high phase
    issue_event(1);
    wait_out(1);
    for (int i = 0; i < 3; i++) issue_event(1);
    check("queue_pending3", 32'(PENDING), 3);
    check("queue_ovf", 32'(OVERFLOW), 0);
    for (int k = 2; k >= 0; k--) begin
      wait_busy(0);
      check("queue_gap_low", 32'(OUT_LEVEL), 0);
      check("queue_pending_idle", 32'(PENDING), 32'(k + 1));
      step();
      check("queue_gap_one_idle", 32'(OUT_LEVEL), 1);
      check("queue_pending_step", 32'(PENDING), 32'(k));
    end
    wait_busy(0);
    step();
    check("queue_final_idle", 32'(BUSY), 0);
    drain();

    // Overflow: five events while busy, only three fit
    issue_event(1);
    wait_out(1);
    for (int i = 0; i < 5; i++) issue_event(i < 3);
    check("ovf_pending_sat", 32'(PENDING), 3);
    check("ovf_set", 32'(OVERFLOW), 1);
    CLEAR_OVF = 1'b1;
    step();
    CLEAR_OVF = 1'b0;
    check("ovf_clear", 32'(OVERFLOW), 0);
    EVENT = 1'b1;
    CLEAR_OVF = 1'b1;
    step();
    EVENT = 1'b0;
    CLEAR_OVF = 1'b0;
    check("ovf_set_beats_clear", 32'(OVERFLOW), 1);
    check("ovf_pending_hold", 32'(PENDING), 3);
    drain();
    CLEAR_OVF = 1'b1;
    step();
    CLEAR_OVF = 1'b0;
    check("ovf_clear_after_drain", 32'(OVERFLOW), 0);

    // Simultaneous inc/dec in the IDLE gap cycle
    issue_event(1);
    wait_out(1);
    issue_event(1);
    check("incdec_pending_before", 32'(PENDING), 1);
    wait_busy(0);
    check("incdec_idle_pending", 32'(PENDING), 1);
    issue_event(1);
    check("incdec_pending_hold", 32'(PENDING), 1);
    check("incdec_out_rise", 32'(OUT_LEVEL), 1);
    drain();

    // Asynchronous reset mid-pulse discards everything queued
    issue_event(1);
    wait_out(1);
    issue_event(1);
    issue_event(1);
    check("rstmid_pending2", 32'(PENDING), 2);
    check("rstmid_out_high", 32'(OUT_LEVEL), 1);
    #2;
    RESET = 1'b1;
    #1;
    check("rstmid_out", 32'(OUT_LEVEL), 0);
    check("rstmid_pending", 32'(PENDING), 0);
    check("rstmid_busy", 32'(BUSY), 0);
    exp_q.delete();
    exp_low_q.delete();
    repeat (3) step();
    RESET = 1'b0;
    repeat (100) step();
    check("rstmid_no_pulse_out", 32'(OUT_LEVEL), 0);
    check("rstmid_no_pulse_busy", 32'(BUSY), 0);

    // Tick gating: no strobes, so the high phase must not advance
    gen_en = 1'b0;
    step();
    issue_event(1);
    wait_out(1);
    check("gate_tick_start", 32'(TICK_DBG), 0);
    repeat (1000) step();
    check("gate_out_held", 32'(OUT_LEVEL), 1);
    check("gate_tick_frozen", 32'(TICK_DBG), 0);
    check("gate_state_on", 32'(STATE_DBG), 32'(ST_ON));
    gen_en = 1'b1;
    drain();

    check("sb_high_empty", 32'(exp_q.size()), 0);
    check("sb_low_empty", 32'(exp_low_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Output-side counterpart of the debounced-input path.
- Takes one-cycle internal events and drives a clean external level (LED, relay, buzzer, handshake line) on OUT_LEVEL.
- Each event produces a high time of ON_TICKS ticks followed by a low guard time of OFF_TICKS ticks, so the far end never sees chatter or sub-minimum pulses.
- Events arriving while busy are queued in a saturating pending counter. Ticks come from the shared PULSE_5MS timer strobe.

Parameters:
- ON_TICKS, 5, number of PULSE_5MS ticks OUT_LEVEL is held high per event; legal range 1..255.
- OFF_TICKS, 5, number of PULSE_5MS ticks OUT_LEVEL is held low after each high phase; legal range 1..255.
- CNT_W, 4, width of the pending-event counter; max queue depth is 2^CNT_W-1.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- PULSE_5MS  in  1  one-CLK strobe every 5 ms from the timer block.
- EVENT  in  1  one-CLK request for one output pulse; level inputs are counted once per high cycle.
- CLEAR_OVF  in  1  one-CLK clear of OVERFLOW.
- OUT_LEVEL  out  1  stretched output level, registered.
- BUSY  out  1  high when state is not IDLE; decoded from the state register.
- PENDING  out  CNT_W  queued events not yet started.
- OVERFLOW  out  1  sticky flag: an EVENT was dropped because PENDING was saturated.

Behaviour:
- Reset (async, RESET=1): state=IDLE, OUT_LEVEL=0, PENDING=0, OVERFLOW=0, tick_cnt=0. OUT_LEVEL goes low immediately, even mid-pulse.
- Pending counter (per clock):
  - inc = EVENT.
  - dec = (state==IDLE && PENDING!=0).
  - inc&dec: PENDING unchanged.
  - inc only at PENDING==2^CNT_W-1: PENDING holds, OVERFLOW<=1.
  - dec never underflows, because it is gated by PENDING!=0.
- OVERFLOW: set has priority over CLEAR_OVF in the same cycle; otherwise CLEAR_OVF clears it.
- FSM states: IDLE, ON, OFF. tick_cnt is 8 bits.
- IDLE:
  - If PENDING!=0: next state ON, OUT_LEVEL<=1, tick_cnt<=0, PENDING decrements.
  - PULSE_5MS is ignored in IDLE.
- ON:
  - On PULSE_5MS with tick_cnt==ON_TICKS-1: next state OFF, OUT_LEVEL<=0, tick_cnt<=0.
  - Else on PULSE_5MS: tick_cnt++.
  - No PULSE_5MS: hold.
- OFF:
  - On PULSE_5MS with tick_cnt==OFF_TICKS-1: next state IDLE, tick_cnt<=0.
  - Else on PULSE_5MS: tick_cnt++.
  - OUT_LEVEL stays 0.
- Latency:
  - EVENT with empty queue in IDLE: PENDING=1 at the next edge; OUT_LEVEL=1 one edge later (2 CLK).
  - PENDING returns to 0 on that same edge.
- High time: between (ON_TICKS-1) and ON_TICKS tick periods, because the first tick is asynchronous to entry; same rule for low time.
- Back-to-back events: leaving OFF with PENDING!=0 costs one IDLE cycle before the next ON; no merging of events.
- EVENT during ON/OFF: only queued; the current phase is never extended or restarted.
- PULSE_5MS and EVENT in the same cycle: each is handled independently as above.
- BUSY=1 in ON and OFF, 0 in IDLE.

Decomposition:
- Shared package holds:
  - state encodings ST_IDLE=2'd0, ST_ON=2'd1, ST_OFF=2'd2;
  - the 8-bit tick counter width constant;
  - default ON/OFF tick counts used by the LED/relay instances.
- One sub-module is natural: event_counter.
  - CNT_W-wide saturating up/down counter.
  - Ports: inc, dec, count, ovf_set.
  - Also reusable by the debounced-button event path.
- FSM and tick counter remain in pulse_stretcher.

Test Plan:
- Bench conditions: ON_TICKS=3, OFF_TICKS=2, CNT_W=2; PULSE_5MS every 10 CLK.
- Single event: EVENT at cycle 0 -> PENDING=1 at edge 1, OUT_LEVEL=1 at edge 2; OUT_LEVEL=0 on the edge after the 3rd PULSE_5MS; BUSY falls on the edge after the 2nd subsequent PULSE_5MS; PENDING=0 throughout.
- Queueing: 3 EVENTs during the first ON phase -> PENDING=3; exactly 4 high pulses on OUT_LEVEL, each separated by a 2-tick low phase; PENDING steps 3,2,1,0; OVERFLOW=0.
- Overflow: 5 EVENTs while busy -> PENDING saturates at 3, OVERFLOW=1. CLEAR_OVF alone -> OVERFLOW=0. CLEAR_OVF coinciding with a dropped EVENT -> OVERFLOW stays 1.
- Simultaneous inc/dec: EVENT in the IDLE cycle where PENDING=1 -> PENDING stays 1 and OUT_LEVEL rises next edge.
- Reset mid-pulse: assert RESET while OUT_LEVEL=1 with PENDING=2 -> OUT_LEVEL=0, PENDING=0, BUSY=0 with no clock edge; after release, no pulse without a new EVENT.
- Tick gating: hold PULSE_5MS=0 for 1000 CLK during ON -> OUT_LEVEL stays 1 and tick_cnt is frozen.
